// File: rtl/mmu_pwr_ctrl.sv
// Bank-switching MMU register file plus power-button controller (hold/run/press/off).
// Optional combinational bank readback is enabled by defining BANK_READBACK_EN.
module mmu_pwr_ctrl #(
    parameter int          NWIN     = 4,
    parameter int          BANK_W   = 8,
    parameter logic [15:0] REG_BASE = 16'h0000,
    parameter int          RST_HOLD = 800000,
    parameter int          OFF_HOLD = 8000000,
    parameter int          CNT_W    = 24,
    localparam int         WSEL_W   = $clog2(NWIN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       addr,
    input  logic [7:0]        din,
    input  logic              rw,
    input  logic              bus_cyc,
    input  logic              pwr_btn,
    output logic [WSEL_W-1:0] win_sel,
    output logic [BANK_W-1:0] bank_out,
    output logic [7:0]        dout,
    output logic              dout_oe,
    output logic              sys_rst_n,
    output logic              pwr_hold
);

    localparam logic [1:0] ST_HOLD  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PRESS = 2'd2;
    localparam logic [1:0] ST_OFF   = 2'd3;

    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_HOLD - 1);
    localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(OFF_HOLD - 1);
    localparam logic [15:0]      NWIN_16  = 16'(NWIN);

    logic              btn_meta_r;
    logic              btn_sync_r;
    logic [1:0]        state_r;
    logic [1:0]        state_nxt_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_nxt_s;
    logic              sys_rst_n_r;
    logic              pwr_hold_r;
    logic [BANK_W-1:0] bank_r [NWIN];
    logic [15:0]       offset_s;
    logic              hit_s;
    logic [WSEL_W-1:0] idx_s;
    logic              wr_en_s;

    // Full 16-bit compare: offset is only meaningful when addr >= REG_BASE.
    assign offset_s = addr - REG_BASE;
    assign hit_s    = (addr >= REG_BASE) && (offset_s < NWIN_16);
    assign idx_s    = offset_s[WSEL_W-1:0];
    assign wr_en_s  = bus_cyc && !rw && hit_s && sys_rst_n_r;

    assign win_sel   = addr[15 -: WSEL_W];
    assign bank_out  = bank_r[win_sel];
    assign sys_rst_n = sys_rst_n_r;
    assign pwr_hold  = pwr_hold_r;

    // Two-flop synchroniser for the raw button.
    always_ff @(posedge clk) begin
        if (!rst) begin
            btn_meta_r <= 1'b0;
            btn_sync_r <= 1'b0;
        end else begin
            btn_meta_r <= pwr_btn;
            btn_sync_r <= btn_meta_r;
        end
    end

    // Next-state and hold-counter logic; the counter never passes its terminal value.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            ST_HOLD: begin
                if (btn_sync_r) begin
                    state_nxt_s = ST_PRESS;
                    cnt_nxt_s   = CNT_ZERO;
                end else if (cnt_r == RST_LAST) begin
                    state_nxt_s = ST_RUN;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    cnt_nxt_s   = cnt_r + CNT_ONE;
                end
            end
            ST_RUN: begin
                if (btn_sync_r) begin
                    state_nxt_s = ST_PRESS;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_PRESS: begin
                if (!btn_sync_r) begin
                    state_nxt_s = ST_HOLD;
                    cnt_nxt_s   = CNT_ZERO;
                end else if (cnt_r == OFF_LAST) begin
                    state_nxt_s = ST_OFF;
                end else begin
                    cnt_nxt_s   = cnt_r + CNT_ONE;
                end
            end
            ST_OFF: begin
                state_nxt_s = ST_OFF;
            end
            default: begin
                state_nxt_s = ST_HOLD;
                cnt_nxt_s   = CNT_ZERO;
            end
        endcase
    end

    // State, counter and registered power outputs derived from the next state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r     <= ST_HOLD;
            cnt_r       <= CNT_ZERO;
            sys_rst_n_r <= 1'b0;
            pwr_hold_r  <= 1'b1;
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            sys_rst_n_r <= (state_nxt_s == ST_RUN);
            pwr_hold_r  <= (state_nxt_s != ST_OFF);
        end
    end

    // Bank registers: system reset clears all and wins over a simultaneous write.
    always_ff @(posedge clk) begin
        if (!rst || !sys_rst_n_r) begin
            for (int i = 0; i < NWIN; i++) begin
                bank_r[i] <= {BANK_W{1'b0}};
            end
        end else if (wr_en_s) begin
            bank_r[idx_s] <= BANK_W'(din);
        end else begin
            bank_r[idx_s] <= bank_r[idx_s];
        end
    end

`ifdef BANK_READBACK_EN
    assign dout_oe = rst && bus_cyc && rw && hit_s;
    assign dout    = dout_oe ? 8'(bank_r[idx_s]) : 8'h00;
`else
    assign dout_oe = 1'b0;
    assign dout    = 8'h00;
`endif

endmodule

// File: tb/tb_mmu_pwr_ctrl.sv
// Directed self-checking bench for mmu_pwr_ctrl with short hold times.
module tb_mmu_pwr_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] addr;
    logic [7:0]  din;
    logic        rw;
    logic        bus_cyc;
    logic        pwr_btn;
    logic [1:0]  win_sel;
    logic [7:0]  bank_out;
    logic [7:0]  dout;
    logic        dout_oe;
    logic        sys_rst_n;
    logic        pwr_hold;

    int checks   = 0;
    int failures = 0;

    mmu_pwr_ctrl #(
        .NWIN(4), .BANK_W(8), .REG_BASE(16'h0000),
        .RST_HOLD(10), .OFF_HOLD(50), .CNT_W(8)
    ) dut (
        .clk(clk), .rst(rst), .addr(addr), .din(din), .rw(rw),
        .bus_cyc(bus_cyc), .pwr_btn(pwr_btn), .win_sel(win_sel),
        .bank_out(bank_out), .dout(dout), .dout_oe(dout_oe),
        .sys_rst_n(sys_rst_n), .pwr_hold(pwr_hold)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
        addr    = a;
        din     = d;
        rw      = 1'b0;
        bus_cyc = 1'b1;
        tick();
        bus_cyc = 1'b0;
        rw      = 1'b1;
    endtask

    task automatic check_bank(input string tag, input int w, input logic [7:0] exp);
        addr = 16'(w) << 14;
        #1;
        chk(tag, {24'h0, bank_out}, {24'h0, exp});
    endtask

    initial begin
        rst = 1'b0; addr = 16'h0000; din = 8'h00; rw = 1'b1;
        bus_cyc = 1'b0; pwr_btn = 1'b0;

        tick(); tick();
        chk("rst_sys_rst_n", {31'h0, sys_rst_n}, 32'h0);
        chk("rst_pwr_hold",  {31'h0, pwr_hold},  32'h1);
        chk("rst_dout_oe",   {31'h0, dout_oe},   32'h0);
        chk("rst_dout",      {24'h0, dout},      32'h0);
        chk("rst_bank0",     {24'h0, bank_out},  32'h0);

        // Ten edges of HOLD after release, then RUN.
        rst = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            chk("hold_sys_rst_n", {31'h0, sys_rst_n}, (i == 10) ? 32'h1 : 32'h0);
            chk("hold_pwr_hold",  {31'h0, pwr_hold},  32'h1);
        end

        bus_write(16'h0002, 8'hA5);
        addr = 16'h8000;
        #1;
        chk("win_sel_8000", {30'h0, win_sel}, 32'h2);
        chk("bank2_a5",     {24'h0, bank_out}, 32'hA5);

        bus_write(16'h0004, 8'h55);
        bus_write(16'h0102, 8'hFF);
        bus_write(16'hFFFF, 8'hEE);
        check_bank("oor_bank0", 0, 8'h00);
        check_bank("oor_bank1", 1, 8'h00);
        check_bank("oor_bank2", 2, 8'hA5);
        check_bank("oor_bank3", 3, 8'h00);

        bus_write(16'h0000, 8'h11);
        check_bank("bank0_11", 0, 8'h11);

        bus_write(16'h0003, 8'h3C);
        addr = 16'h0003; rw = 1'b1; bus_cyc = 1'b1;
        #1;
`ifdef BANK_READBACK_EN
        chk("rd_dout",    {24'h0, dout},    32'h3C);
        chk("rd_dout_oe", {31'h0, dout_oe}, 32'h1);
`else
        chk("rd_dout",    {24'h0, dout},    32'h0);
        chk("rd_dout_oe", {31'h0, dout_oe}, 32'h0);
`endif
        addr = 16'h0004;
        #1;
        chk("rd_oor_oe", {31'h0, dout_oe}, 32'h0);
        bus_cyc = 1'b0;
        tick();

        // Short press: sync latency 2, PRESS from edge 3, release 20 edges later.
        pwr_btn = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 2) chk("press_pre", {31'h0, sys_rst_n}, 32'h1);
            if (i == 3) chk("press_in",  {31'h0, sys_rst_n}, 32'h0);
        end
        pwr_btn = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            tick();
            if (k == 12) chk("rel_still_low", {31'h0, sys_rst_n}, 32'h0);
            if (k == 13) chk("rel_run",       {31'h0, sys_rst_n}, 32'h1);
            chk("rel_pwr_hold", {31'h0, pwr_hold}, 32'h1);
        end
        for (int w = 0; w < 4; w++) check_bank("clr_bank", w, 8'h00);

        // Write coinciding with reset must lose.
        bus_write(16'h0001, 8'h77);
        check_bank("bank1_77", 1, 8'h77);
        rst = 1'b0;
        bus_write(16'h0001, 8'h99);
        check_bank("rst_wr_bank1", 1, 8'h00);
        rst = 1'b1;
        for (int i = 1; i <= 10; i++) tick();
        chk("rerun", {31'h0, sys_rst_n}, 32'h1);

        // Long press: OFF entered on edge 53 after pressing.
        pwr_btn = 1'b1;
        for (int i = 1; i <= 60; i++) begin
            tick();
            if (i == 52) chk("off_pre",  {31'h0, pwr_hold}, 32'h1);
            if (i == 53) chk("off_hold", {31'h0, pwr_hold}, 32'h0);
            if (i == 53) chk("off_rstn", {31'h0, sys_rst_n}, 32'h0);
        end
        pwr_btn = 1'b0;
        for (int i = 1; i <= 15; i++) tick();
        chk("off_sticky_hold", {31'h0, pwr_hold},  32'h0);
        chk("off_sticky_rstn", {31'h0, sys_rst_n}, 32'h0);

        rst = 1'b0;
        tick();
        chk("off_rst_hold", {31'h0, pwr_hold},  32'h1);
        chk("off_rst_rstn", {31'h0, sys_rst_n}, 32'h0);
        rst = 1'b1;
        for (int i = 1; i <= 10; i++) tick();
        chk("off_recover", {31'h0, sys_rst_n}, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
